transpose_ctrl: RTL and testbench

TRANSPOSE_CTRL -- requirements
Module: transpose_ctrl

---
 rtl/transpose_ctrl_pkg.sv | 24 ++
 rtl/transpose_ctrl_idx_counter.sv | 46 ++++
 rtl/transpose_ctrl.sv | 161 ++++++++++++++++
 tb/tb_transpose_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/transpose_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// transpose_ctrl_pkg
// Shared constants, FSM state encoding and the address-transpose helper for
// the 8x8 coefficient transpose controller.
// -----------------------------------------------------------------------------
package transpose_ctrl_pkg;

  localparam int BLK_N  = 8;              // block dimension (8x8)
  localparam int DEPTH  = BLK_N * BLK_N;  // words per block / RAM depth
  localparam int ADDR_W = 6;              // RAM word address width

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Swap the row and column fields of a linear index so that a row-major
  // counter walks the RAM in column-major order.
  function automatic logic [ADDR_W-1:0] transpose_addr(input logic [ADDR_W-1:0] idx);
    return {idx[2:0], idx[5:3]};
  endfunction

endpackage

// File: rtl/transpose_ctrl_idx_counter.sv
// -----------------------------------------------------------------------------
// idx_counter
// 6-bit block index counter. Advances by one when en is high and wraps from
// DEPTH-1 back to 0; wrap flags the enabled cycle that performs the wrap.
// Ports:
//   clk, clr_n  clock and asynchronous active-low reset
//   en          advance the count this cycle
//   cnt         current count
//   wrap        en is high and the count is at DEPTH-1
// -----------------------------------------------------------------------------
module idx_counter
  import transpose_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              clr_n,
  input  logic              en,
  output logic [ADDR_W-1:0] cnt,
  output logic              wrap
);

  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;

  // Next count; the natural 6-bit overflow gives the 63 -> 0 wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = cnt_q + 6'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= 6'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign wrap = en && (cnt_q == 6'(DEPTH - 1));

endmodule

// File: rtl/transpose_ctrl.sv
// -----------------------------------------------------------------------------
// transpose_ctrl
// Collects a 64-word block of row-DCT coefficients into an external RAM in
// row-major order, then reads it back in column-major order to the
// column-DCT stage with a one-cycle registered output stage.
// Ports:
//   clk, clr_n                      clock, asynchronous active-low reset
//   in_valid/in_ready/in_data       row-major input handshake
//   ram_address, ram_data_in        RAM address and write data
//   ram_cs/read/write/clr           RAM strobes (clr is tied low)
//   ram_data_out                    combinational RAM read data
//   out_valid/out_ready/out_data    column-major output handshake
//   out_last                        marks the 64th output word
//   block_done                      one-cycle pulse after the last word leaves
// -----------------------------------------------------------------------------
module transpose_ctrl
  import transpose_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int N      = 8
) (
  input  logic                       clk,
  input  logic                       clr_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic [$clog2(N*N)-1:0]     ram_address,
  output logic [DATA_W-1:0]          ram_data_in,
  output logic                       ram_cs,
  output logic                       ram_read,
  output logic                       ram_write,
  output logic                       ram_clr,
  input  logic [DATA_W-1:0]          ram_data_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_last,
  output logic                       block_done
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_cnt, rd_cnt;
  logic              wr_en, rd_en;
  logic              wr_wrap, rd_wrap;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              block_done_q, block_done_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_accept;

  assign out_accept = out_valid_q && out_ready;

  // RAM access strobes: writes only in FILL, reads in DRAIN whenever the
  // output register is empty or being emptied this cycle.
  always_comb begin
    in_ready = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        wr_en    = in_valid;
      end
      DRAIN: begin
        rd_en = !out_valid_q || out_ready;
      end
      FLUSH: begin
        rd_en = 1'b0;
      end
      default: begin
        rd_en = 1'b0;
      end
    endcase
  end

  idx_counter u_wr_cnt (
    .clk   (clk),
    .clr_n (clr_n),
    .en    (wr_en),
    .cnt   (wr_cnt),
    .wrap  (wr_wrap)
  );

  idx_counter u_rd_cnt (
    .clk   (clk),
    .clr_n (clr_n),
    .en    (rd_en),
    .cnt   (rd_cnt),
    .wrap  (rd_wrap)
  );

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (wr_wrap) state_d = DRAIN;
        else         state_d = FILL;
      end
      DRAIN: begin
        if (rd_wrap) state_d = FLUSH;
        else         state_d = DRAIN;
      end
      FLUSH: begin
        if (out_accept) state_d = FILL;
        else            state_d = FLUSH;
      end
      default: state_d = FILL;
    endcase
  end

  // Output register next values: load on a read, retire the last word in FLUSH.
  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    block_done_d = 1'b0;
    if (rd_en) begin
      out_data_d  = ram_data_out;
      out_valid_d = 1'b1;
      out_last_d  = rd_wrap;
    end else if ((state_q == FLUSH) && out_accept) begin
      out_valid_d  = 1'b0;
      out_last_d   = 1'b0;
      block_done_d = 1'b1;
    end else begin
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= FILL;
      out_data_q   <= {DATA_W{1'b0}};
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      block_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      block_done_q <= block_done_d;
    end
  end

  assign ram_cs      = wr_en || rd_en;
  assign ram_write   = wr_en;
  assign ram_read    = rd_en;
  assign ram_clr     = 1'b0;
  assign ram_address = rd_en ? transpose_addr(rd_cnt) : wr_cnt;
  assign ram_data_in = wr_en ? in_data : {DATA_W{1'b0}};

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign block_done = block_done_q;

endmodule

// File: tb/tb_transpose_ctrl.sv
// -----------------------------------------------------------------------------
// tb_transpose_ctrl
// Directed scenarios with a scoreboard: expected column-major words are queued
// when a block is written and popped as the DUT hands them out.
// -----------------------------------------------------------------------------
module tb_transpose_ctrl;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [5:0]  ram_address;
  logic [15:0] ram_data_in;
  logic        ram_cs, ram_read, ram_write, ram_clr;
  logic [15:0] ram_data_out;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        block_done;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mem[0:63];

  transpose_ctrl #(.DATA_W(16), .N(8)) dut (
    .clk          (clk),
    .clr_n        (clr_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_cs       (ram_cs),
    .ram_read     (ram_read),
    .ram_write    (ram_write),
    .ram_clr      (ram_clr),
    .ram_data_out (ram_data_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .block_done   (block_done)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous write, combinational read.
  always @(posedge clk) begin
    if (ram_cs && ram_write) mem[ram_address] <= ram_data_in;
  end
  assign ram_data_out = (ram_cs && ram_read) ? mem[ram_address] : 16'h0000;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Write one block of base+i (i = 0..63); toggle alternates in_valid.
  task automatic fill_block(input int base, input bit toggle);
    int acc = 0;
    int cyc = 0;
    int nwrites = 0;
    bit phase = 1'b0;
    while (acc < 64 && cyc < 400) begin
      @(negedge clk);
      in_valid = toggle ? phase : 1'b1;
      phase    = !phase;
      in_data  = 16'(base + acc);
      #1;
      if (ram_write === 1'b1) nwrites++;
      checks++;
      if (in_ready !== 1'b1 || ram_read !== 1'b0) begin
        errors++;
        $display("FAIL fill_ready: in_ready=%b ram_read=%b want 1/0", in_ready, ram_read);
      end
      if (in_valid) begin
        checks++;
        if (ram_write !== 1'b1 || ram_cs !== 1'b1 || ram_address !== 6'(acc) || ram_data_in !== in_data) begin
          errors++;
          $display("FAIL fill_write: we=%b addr=%0d data=%0d want 1/%0d/%0d",
                   ram_write, ram_address, ram_data_in, acc, in_data);
        end
        acc++;
      end
      cyc++;
    end
    checks++;
    if (acc != 64) begin
      errors++;
      $display("FAIL fill_timeout: accepted %0d want 64", acc);
    end
    checks++;
    if (nwrites != 64) begin
      errors++;
      $display("FAIL fill_strobes: ram_write strobes %0d want 64", nwrites);
    end
    // Output word k is the element at row k%8, column k/8.
    for (int k = 0; k < 64; k++) exp_q.push_back(16'(base + (k % 8) * 8 + k / 8));
  endtask

  // Read back a block; optional stall of stall_len cycles when word stall_at
  // is presented; junk drives in_valid=1 with 16'hFFFF; stops after stop_at words.
  task automatic drain_block(input int stall_at, input int stall_len, input bit junk, input int stop_at);
    int n = 0;
    int cyc = 0;
    int left = stall_len;
    bit stalled;
    logic [15:0] exp;
    while (n < stop_at && cyc < 400) begin
      @(negedge clk);
      stalled   = (out_valid === 1'b1) && (n == stall_at) && (left > 0);
      if (stalled) left--;
      out_ready = !stalled;
      in_valid  = junk;
      in_data   = 16'hFFFF;
      #1;
      checks++;
      if (in_ready !== 1'b0 || ram_write !== 1'b0 || block_done !== 1'b0) begin
        errors++;
        $display("FAIL drain_idle: in_ready=%b ram_write=%b block_done=%b want 0/0/0",
                 in_ready, ram_write, block_done);
      end
      if (stalled) begin
        checks++;
        if (ram_read !== 1'b0 || ram_cs !== 1'b0 || out_valid !== 1'b1 || out_data !== exp_q[0]) begin
          errors++;
          $display("FAIL stall_hold: rd=%b cs=%b valid=%b data=%0d want 0/0/1/%0d",
                   ram_read, ram_cs, out_valid, out_data, exp_q[0]);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty: got word %0d with nothing expected", out_data);
        end else begin
          exp = exp_q.pop_front();
          if (out_data !== exp || out_last !== (n == 63)) begin
            errors++;
            $display("FAIL out_word[%0d]: data=%0d last=%b want %0d/%b",
                     n, out_data, out_last, exp, (n == 63));
          end
        end
        n++;
      end
      cyc++;
    end
    checks++;
    if (n != stop_at || left != 0) begin
      errors++;
      $display("FAIL drain_count: words=%0d stall_left=%0d want %0d/0", n, left, stop_at);
    end
    if (stop_at == 64) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (block_done !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0) begin
        errors++;
        $display("FAIL block_done: done=%b in_ready=%b valid=%b last=%b want 1/1/0/0",
                 block_done, in_ready, out_valid, out_last);
      end
      @(negedge clk);
      #1;
      checks++;
      if (block_done !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse: block_done=%b want 0 one cycle later", block_done);
      end
    end
  endtask

  task automatic test_reset();
    clr_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || block_done !== 1'b0 || out_data !== 16'h0000 ||
        in_ready !== 1'b1 || ram_write !== 1'b0 || ram_read !== 1'b0 || ram_clr !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b last=%b done=%b data=%0d in_ready=%b we=%b rd=%b clr=%b want 0/0/0/0/1/0/0/0",
               out_valid, out_last, block_done, out_data, in_ready, ram_write, ram_read, ram_clr);
    end
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic test_ordering();
    fill_block(0, 1'b0);
    drain_block(-1, 0, 1'b0, 64);
  endtask

  task automatic test_backpressure();
    fill_block(0, 1'b0);
    drain_block(10, 5, 1'b0, 64);
  endtask

  task automatic test_input_ignored();
    fill_block(300, 1'b0);
    drain_block(-1, 0, 1'b1, 64);
  endtask

  task automatic test_reset_mid_drain();
    fill_block(500, 1'b0);
    drain_block(-1, 0, 1'b0, 21);
    @(posedge clk);
    #2;
    clr_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_drain: valid=%b last=%b in_ready=%b want 0/0/1",
               out_valid, out_last, in_ready);
    end
    exp_q.delete();
    @(negedge clk);
    clr_n = 1'b1;
    fill_block(700, 1'b0);
    drain_block(-1, 0, 1'b0, 64);
  endtask

  task automatic test_back_to_back();
    fill_block(0, 1'b0);
    drain_block(-1, 0, 1'b0, 64);
    fill_block(100, 1'b0);
    drain_block(-1, 0, 1'b0, 64);
  endtask

  task automatic test_write_strobe();
    fill_block(900, 1'b1);
    drain_block(-1, 0, 1'b0, 64);
  endtask

  initial begin
    test_reset();
    test_ordering();
    test_backpressure();
    test_input_ignored();
    test_reset_mid_drain();
    test_back_to_back();
    test_write_strobe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
